beamform_power_trigger: RTL and testbench

- Parametrised successor to the fixed 8-channel beam summer: NCHAN channels of NSAMP samples per clock are aligned by per-channel compile-time delays and summed per sample.
- Each beam sample is squared. Squares are summed across the clock and integrated over a sliding window of WINDOW clocks.
- The integrated power is compared against a runtime threshold, with holdoff, a warm-up blanking period and a trigger counter.
- One instance per beam; sits between the channel pipeline and the trigger combiner.

---
 rtl/beamform_pkg.sv | 30 +++
 rtl/beamform_power_trigger_align.sv | 45 ++++
 rtl/beamform_power_trigger.sv | 137 +++++++++++++
 tb/tb_beamform_power_trigger.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/beamform_pkg.sv
// beamform_pkg: shared helpers and pipeline constants for beam modules
package beamform_pkg;

   localparam int BEAM_LAT  = 3;
   localparam int POWER_LAT = 6;
   localparam int TRIG_LAT  = 7;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) r = ((1 << i) < v) ? i + 1 : r;
      return r;
   endfunction

   function automatic int base_delay(input logic [127:0] d, input int i, input int nsamp);
      return int'(d[8*i +: 8]) / nsamp;
   endfunction

   function automatic int samp_delay(input logic [127:0] d, input int i, input int nsamp);
      return int'(d[8*i +: 8]) % nsamp;
   endfunction

   function automatic int max_base(input logic [127:0] d, input int nchan, input int nsamp);
      int m;
      m = 0;
      for (int i = 0; i < nchan; i++) m = (base_delay(d, i, nsamp) > m) ? base_delay(d, i, nsamp) : m;
      return m;
   endfunction

endpackage

// File: rtl/beamform_power_trigger_align.sv
// beam_align_chan: one channel's whole-clock delay line, sample realign and output register
module beam_align_chan #(
   parameter int NBIT  = 5,
   parameter int NSAMP = 8,
   parameter int DELAY = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NSAMP*NBIT-1:0] din_i,
   output logic [NSAMP*NBIT-1:0] dout_o
);

   localparam int W     = NSAMP * NBIT;
   localparam int BASE  = DELAY / NSAMP;
   localparam int OFF   = DELAY % NSAMP;
   localparam int DEPTH = BASE + ((OFF > 0) ? 1 : 0);

   logic [W-1:0] al;

   if (DEPTH == 0) begin : g_direct
      assign al = din_i;
   end else begin : g_srl
      logic [W-1:0] sr_q [DEPTH];
      // sr_q[k] holds din_i delayed k+1 clocks; no reset, warm-up flushes it
      always_ff @(posedge clk) begin
         sr_q[0] <= din_i;
         for (int k = 1; k < DEPTH; k++) sr_q[k] <= sr_q[k-1];
      end
      for (genvar s = 0; s < NSAMP; s++) begin : g_s
         if (s < OFF) begin : g_late
            assign al[NBIT*s +: NBIT] = sr_q[DEPTH-1][NBIT*(NSAMP+s-OFF) +: NBIT];
         end else if (BASE == 0) begin : g_now
            assign al[NBIT*s +: NBIT] = din_i[NBIT*(s-OFF) +: NBIT];
         end else begin : g_early
            assign al[NBIT*s +: NBIT] = sr_q[BASE-1][NBIT*(s-OFF) +: NBIT];
         end
      end
   end

   // aligned word register
   always_ff @(posedge clk) begin
      dout_o <= rst ? '0 : al;
   end

endmodule

// File: rtl/beamform_power_trigger.sv
// beamform_power_trigger: aligned beam sum, windowed power and threshold trigger
module beamform_power_trigger
   import beamform_pkg::*;
#(
   parameter int                 NCHAN   = 8,
   parameter int                 NSAMP   = 8,
   parameter int                 NBIT    = 5,
   parameter logic [NCHAN*8-1:0] DELAYS  = '0,
   parameter int                 WINDOW  = 4,
   parameter int                 HOLDOFF = 16,
   localparam int                SW      = NBIT + clog2(NCHAN),
   localparam int                QW      = 2*SW + clog2(NSAMP),
   localparam int                PW      = QW + clog2(WINDOW)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NCHAN*NSAMP*NBIT-1:0] din,
   input  logic [NCHAN-1:0]            chan_mask,
   input  logic [PW-1:0]               thresh,
   input  logic                        thresh_wr,
   output logic [NSAMP*SW-1:0]         beam_out,
   output logic [PW-1:0]               power_out,
   output logic                        trig,
   output logic [15:0]                 trig_count
);

   localparam int FILL = max_base(128'(DELAYS), NCHAN, NSAMP) + 2 + WINDOW + POWER_LAT;
   localparam int FW   = clog2(FILL + 1);
   localparam int HW   = clog2(HOLDOFF + 1);
   localparam int CW   = NSAMP * NBIT;

   logic [NCHAN*CW-1:0]  al;
   logic [NCHAN-1:0]     mask_q;
   logic signed [SW-1:0] h0_d [NSAMP];
   logic signed [SW-1:0] h1_d [NSAMP];
   logic signed [SW-1:0] h0_q [NSAMP];
   logic signed [SW-1:0] h1_q [NSAMP];
   logic signed [SW-1:0] beam_q [NSAMP];
   logic [2*SW-1:0]      sq_d [NSAMP];
   logic [2*SW-1:0]      sq_q [NSAMP];
   logic [QW-1:0]        pclk_d, pclk_q;
   logic [QW-1:0]        win_q [WINDOW];
   logic [PW-1:0]        run_q, thr_q;
   logic [HW-1:0]        hold_q;
   logic [FW-1:0]        wcnt_q;
   logic                 trig_q, fire;
   logic [15:0]          cnt_q;

   for (genvar c = 0; c < NCHAN; c++) begin : g_ch
      beam_align_chan #(.NBIT(NBIT), .NSAMP(NSAMP), .DELAY(int'(DELAYS[8*c +: 8]))) u_align (
         .clk    (clk),
         .rst    (rst),
         .din_i  (din[CW*c +: CW]),
         .dout_o (al[CW*c +: CW])
      );
   end

   // masked per-sample sums, split into lower and upper channel halves
   always_comb begin
      for (int s = 0; s < NSAMP; s++) begin
         h0_d[s] = '0;
         h1_d[s] = '0;
         for (int c = 0; c < NCHAN; c++) begin
            if (c < NCHAN/2) h0_d[s] = h0_d[s] + (mask_q[c] ? '0 : SW'($signed(al[NBIT*(NSAMP*c+s) +: NBIT])));
            else h1_d[s] = h1_d[s] + (mask_q[c] ? '0 : SW'($signed(al[NBIT*(NSAMP*c+s) +: NBIT])));
         end
      end
   end

   // squares of the beam samples and their per-clock total
   always_comb begin
      pclk_d = '0;
      for (int s = 0; s < NSAMP; s++) begin
         sq_d[s] = (2*SW)'(beam_q[s]) * (2*SW)'(beam_q[s]);
         pclk_d  = pclk_d + QW'(sq_q[s]);
      end
   end

   // mask, half sums, beam, squares and per-clock power pipeline
   always_ff @(posedge clk) begin
      if (rst) begin
         mask_q <= '0;
         h0_q   <= '{default: '0};
         h1_q   <= '{default: '0};
         beam_q <= '{default: '0};
         sq_q   <= '{default: '0};
         pclk_q <= '0;
      end else begin
         mask_q <= chan_mask;
         h0_q   <= h0_d;
         h1_q   <= h1_d;
         for (int s = 0; s < NSAMP; s++) beam_q[s] <= h0_q[s] + h1_q[s];
         sq_q   <= sq_d;
         pclk_q <= pclk_d;
      end
   end

   // running window sum: add newest per-clock power, drop the one WINDOW clocks old
   always_ff @(posedge clk) begin
      if (rst) begin
         win_q <= '{default: '0};
         run_q <= '0;
      end else begin
         run_q    <= run_q + PW'(pclk_q) - PW'(win_q[WINDOW-1]);
         win_q[0] <= pclk_q;
         for (int i = 1; i < WINDOW; i++) win_q[i] <= win_q[i-1];
      end
   end

   assign fire = (run_q > thr_q) && (hold_q == '0) && (wcnt_q == FW'(FILL));

   // threshold, warm-up, holdoff and trigger counting
   always_ff @(posedge clk) begin
      if (rst) begin
         thr_q  <= '1;
         wcnt_q <= '0;
         hold_q <= '0;
         trig_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         thr_q  <= thresh_wr ? thresh : thr_q;
         wcnt_q <= (wcnt_q == FW'(FILL)) ? wcnt_q : wcnt_q + 1'b1;
         hold_q <= fire ? HW'(HOLDOFF) : ((hold_q == '0) ? hold_q : hold_q - 1'b1);
         trig_q <= fire;
         cnt_q  <= (fire && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
      end
   end

   for (genvar s = 0; s < NSAMP; s++) begin : g_bo
      assign beam_out[SW*s +: SW] = beam_q[s];
   end

   assign power_out  = run_q;
   assign trig       = trig_q;
   assign trig_count = cnt_q;

endmodule

// File: tb/tb_beamform_power_trigger.sv
// tb_beamform_power_trigger: directed checks of alignment, power, threshold, holdoff and warm-up
module tb_beamform_power_trigger;

   logic        clk, rst, thresh_wr;
   logic [7:0]  chan_mask;
   logic [319:0] din_a, din_b;
   logic [18:0] thr_a, pow_a;
   logic [20:0] thr_b, pow_b;
   logic [63:0] beam_a, beam_b;
   logic        trig_a, trig_b;
   logic [15:0] cnt_a, cnt_b;
   int          errs = 0;
   int          checks = 0;

   beamform_power_trigger #(.NCHAN(8), .NSAMP(8), .NBIT(5), .DELAYS(64'h0), .WINDOW(1), .HOLDOFF(16)) u_a (
      .clk(clk), .rst(rst), .din(din_a), .chan_mask(chan_mask), .thresh(thr_a), .thresh_wr(thresh_wr),
      .beam_out(beam_a), .power_out(pow_a), .trig(trig_a), .trig_count(cnt_a)
   );

   beamform_power_trigger #(.NCHAN(8), .NSAMP(8), .NBIT(5), .DELAYS(64'h0B00), .WINDOW(4), .HOLDOFF(16)) u_b (
      .clk(clk), .rst(rst), .din(din_b), .chan_mask(chan_mask), .thresh(thr_b), .thresh_wr(thresh_wr),
      .beam_out(beam_b), .power_out(pow_b), .trig(trig_b), .trig_count(cnt_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic put_a(input int c, input int s, input logic [4:0] v);
      din_a[5*(8*c+s) +: 5] = v;
   endtask

   task automatic put_b(input int c, input int s, input logic [4:0] v);
      din_b[5*(8*c+s) +: 5] = v;
   endtask

   // beam = [12,-12,12,12,12,12,10,6] -> per-clock power 1000
   task automatic load_const();
      din_a = '0;
      put_a(0, 0, 5'h0C); put_a(0, 1, 5'h18); put_a(0, 2, 5'h0C); put_a(0, 3, 5'h0C);
      put_a(0, 4, 5'h0C); put_a(0, 5, 5'h0C); put_a(0, 6, 5'h0A); put_a(0, 7, 5'h06);
      put_a(1, 1, 5'h1C);
   endtask

   initial begin
      rst = 1'b1; thresh_wr = 1'b0; chan_mask = '0;
      din_a = '0; din_b = '0; thr_a = '1; thr_b = '1;
      tick(3);
      check("rst_beam", beam_a, 64'h0);
      check("rst_power", 64'(pow_a), 64'h0);
      check("rst_trig", 64'(trig_a), 64'h0);
      check("rst_count", 64'(cnt_a), 64'h0);
      rst = 1'b0;
      tick(14);

      // alignment: ch1 delayed 11 samples lines up with ch0 one clock later
      put_b(1, 0, 5'h03); put_b(1, 7, 5'h1B);
      tick(1);
      din_b = '0; put_b(0, 3, 5'h03);
      tick(1);
      din_b = '0;
      tick(1);
      check("align_early", beam_b, 64'h0);
      tick(1);
      check("align_s3", beam_b, 64'h0000_0000_0600_0000);
      tick(1);
      check("align_wrap", beam_b, 64'h0000_0000_00FB_0000);
      tick(3);
      check("align_pow_sum", 64'(pow_b), 64'd61);
      tick(3);
      check("align_pow_tail", 64'(pow_b), 64'd25);
      check("align_count", 64'(cnt_b), 64'h0);

      // single clock of ones on every channel
      thr_a = 19'd511; thresh_wr = 1'b1;
      tick(1);
      thresh_wr = 1'b0;
      for (int c = 0; c < 8; c++) for (int s = 0; s < 8; s++) put_a(c, s, 5'h01);
      tick(1);
      din_a = '0;
      tick(1);
      check("ones_beam_t2", beam_a, 64'h0);
      tick(1);
      check("ones_beam_t3", beam_a, 64'h0808_0808_0808_0808);
      tick(3);
      check("ones_power", 64'(pow_a), 64'd512);
      check("ones_trig_t6", 64'(trig_a), 64'h0);
      tick(1);
      check("ones_trig_t7", 64'(trig_a), 64'h1);
      check("ones_count", 64'(cnt_a), 64'h1);
      tick(1);
      check("ones_trig_single", 64'(trig_a), 64'h0);
      tick(20);

      // sustained power 1000 over threshold 999
      thr_a = 19'd999; thresh_wr = 1'b1;
      tick(1);
      thresh_wr = 1'b0;
      load_const();
      tick(3);
      check("const_beam", beam_a, 64'h060A_0C0C_0C0C_F40C);
      tick(3);
      check("const_power", 64'(pow_a), 64'd1000);
      check("const_trig_t6", 64'(trig_a), 64'h0);
      tick(1);
      for (int i = 0; i < 40; i++) begin
         check("holdoff_trig", 64'(trig_a), 64'(i % 17 == 0));
         check("holdoff_count", 64'(cnt_a), 64'(2 + i / 17));
         tick(1);
      end

      // mask every channel, then restore
      chan_mask = 8'hFF;
      tick(2);
      check("mask_beam_m2", beam_a, 64'h060A_0C0C_0C0C_F40C);
      tick(1);
      check("mask_beam_m3", beam_a, 64'h0);
      tick(3);
      check("mask_power", 64'(pow_a), 64'h0);
      for (int i = 0; i < 15; i++) begin
         check("mask_no_trig", 64'(trig_a), 64'h0);
         tick(1);
      end
      chan_mask = 8'h00;
      tick(7);
      check("unmask_power", 64'(pow_a), 64'd1000);
      check("unmask_trig", 64'(trig_a), 64'h1);
      check("unmask_count", 64'(cnt_a), 64'd5);

      // reset during holdoff with count 5
      tick(1);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      check("midrst_count", 64'(cnt_a), 64'h0);
      check("midrst_power", 64'(pow_a), 64'h0);
      check("midrst_beam", beam_a, 64'h0);
      check("midrst_trig", 64'(trig_a), 64'h0);
      for (int i = 1; i < 15; i++) begin
         if (i == 7) check("midrst_power_back", 64'(pow_a), 64'd1000);
         check("thr_reset_no_trig", 64'(trig_a), 64'h0);
         tick(1);
      end

      // warm-up blanks triggers even with threshold 0
      rst = 1'b1;
      tick(1);
      rst = 1'b0; thr_a = '0; thresh_wr = 1'b1;
      tick(1);
      thresh_wr = 1'b0;
      for (int i = 2; i < 11; i++) begin
         check("warmup_no_trig", 64'(trig_a), 64'h0);
         tick(1);
      end
      check("warmup_trig", 64'(trig_a), 64'h1);
      check("warmup_count", 64'(cnt_a), 64'h1);

      // threshold lowered in the cycle power first exceeds it
      din_a = '0; thr_a = 19'd2000; thresh_wr = 1'b1;
      tick(1);
      thresh_wr = 1'b0;
      tick(25);
      load_const();
      tick(6);
      check("wr_power", 64'(pow_a), 64'd1000);
      check("wr_trig_before", 64'(trig_a), 64'h0);
      thr_a = 19'd999; thresh_wr = 1'b1;
      tick(1);
      thresh_wr = 1'b0;
      check("wr_old_thr", 64'(trig_a), 64'h0);
      tick(1);
      check("wr_new_thr", 64'(trig_a), 64'h1);
      check("wr_count", 64'(cnt_a), 64'd2);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
